// File: rtl/pulse_meas.sv
// Measures high then low width of the first full pulse on din after arming; reports via one-cycle valid.
// Optional PULSE_MEAS_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency, same widths).
module pulse_meas #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             din,
    output logic             busy,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [CNT_W-1:0] lo_cnt,
    output logic             valid,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             d_prev_q, d_prev_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             d_s;
    logic             rise;
    logic             fall;

`ifdef PULSE_MEAS_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign d_s = sync2_q;
`else
    assign d_s = din;
`endif

    assign rise = d_s & ~d_prev_q;
    assign fall = ~d_s & d_prev_q;

    always_comb begin
        state_d  = state_q;
        d_prev_d = d_s;
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                // A level already high at arm time is not a pulse start; only an edge is.
                if (rise) begin
                    hcnt_d  = CNT_ONE;
                    lcnt_d  = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (d_s) begin
                    if (hcnt_q == CNT_MAX) begin
                        hi_cnt_d = CNT_MAX;
                        lo_cnt_d = '0;
                        ovf_d    = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end else if (fall) begin
                    lcnt_d  = CNT_ONE;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (rise) begin
                    hi_cnt_d = hcnt_q;
                    lo_cnt_d = lcnt_q;
                    ovf_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end else if (!d_s) begin
                    if (lcnt_q == CNT_MAX) begin
                        hi_cnt_d = hcnt_q;
                        lo_cnt_d = CNT_MAX;
                        ovf_d    = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        lcnt_d = lcnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            d_prev_q <= 1'b0;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_prev_q <= d_prev_d;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign hi_cnt = hi_cnt_q;
    assign lo_cnt = lo_cnt_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_pulse_meas.sv
// Scoreboard bench for pulse_meas: expected reports are queued as pulses are driven, checked when valid fires.
// Also builds with PULSE_MEAS_SYNC_EN, where all report times shift by two cycles.
module tb_pulse_meas;

    localparam int CNT_W = 6;
`ifdef PULSE_MEAS_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             din;
    logic             busy;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;
    logic             valid;
    logic             ovf;

    pulse_meas #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .din    (din),
        .busy   (busy),
        .hi_cnt (hi_cnt),
        .lo_cnt (lo_cnt),
        .valid  (valid),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CNT_W-1:0] hi;
        logic [CNT_W-1:0] lo;
        logic             ovf;
        int               at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Scoreboard monitor: every valid must match the head of the queue in value and cycle.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid cycle %0d: got valid=1, required 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                vectors += 4;
                if (hi_cnt !== mon_e.hi) begin
                    miscompares++;
                    $display("FAIL hi_cnt cycle %0d: got %0d, required %0d", cyc, hi_cnt, mon_e.hi);
                end
                if (lo_cnt !== mon_e.lo) begin
                    miscompares++;
                    $display("FAIL lo_cnt cycle %0d: got %0d, required %0d", cyc, lo_cnt, mon_e.lo);
                end
                if (ovf !== mon_e.ovf) begin
                    miscompares++;
                    $display("FAIL ovf cycle %0d: got %0b, required %0b", cyc, ovf, mon_e.ovf);
                end
                if (cyc != mon_e.at) begin
                    miscompares++;
                    $display("FAIL valid_time: got cycle %0d, required cycle %0d", cyc, mon_e.at);
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].at) begin
            mon_e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_valid: got none by cycle %0d, required at cycle %0d", cyc, mon_e.at);
        end
    end

    task automatic drive(input logic d, input int n);
        din = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm();
        ena = 1'b1;
        @(posedge clk);
        #1;
        ena = 1'b0;
    endtask

    task automatic push(input int hi, input int lo, input logic o, input int at);
        exp_t e;
        e.hi  = CNT_W'(hi);
        e.lo  = CNT_W'(lo);
        e.ovf = o;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int at);
        while (cyc < at) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 5;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        if (hi_cnt !== '0) begin miscompares++; $display("FAIL reset_hi_cnt: got %0d, required 0", hi_cnt); end
        if (lo_cnt !== '0) begin miscompares++; $display("FAIL reset_lo_cnt: got %0d, required 0", lo_cnt); end
        if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b, required 0", valid); end
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %0b, required 0", ovf); end
        rst_n = 1'b1;
        drive(1'b0, 1);
    endtask

    task automatic test_basic();
        int at;
        arm();
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_armed: got %0b, required 1", busy); end
        drive(1'b0, 2);
        drive(1'b1, 5);
        drive(1'b0, 3);
        at = cyc + 1 + SYNC_LAT;
        push(5, 3, 1'b0, at);
        din = 1'b1;
        wait_until(at - 1);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_before: got %0b, required 1", busy); end
        wait_until(at);
        vectors += 2;
        if (valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_at: got %0b, required 1", valid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_drop: got %0b, required 0", busy); end
        wait_until(at + 1);
        vectors++;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_width: got %0b, required 0", valid); end
    endtask

    task automatic test_already_high();
        int at;
        drive(1'b1, 4);
        arm();
        drive(1'b1, 3);
        drive(1'b0, 4);
        drive(1'b1, 2);
        drive(1'b0, 7);
        at = cyc + 1 + SYNC_LAT;
        push(2, 7, 1'b0, at);
        din = 1'b1;
        wait_until(at + 1);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL high_busy_after: got %0b, required 0", busy); end
    endtask

    task automatic test_sat_high();
        drive(1'b0, 2);
        arm();
        push(63, 0, 1'b1, cyc + 64 + SYNC_LAT);
        drive(1'b1, 70);
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL sat_high_busy: got %0b, required 0", busy); end
        if (hi_cnt !== 6'd63) begin miscompares++; $display("FAIL sat_high_hold: got %0d, required 63", hi_cnt); end
        drive(1'b0, 3);
    endtask

    task automatic test_sat_low();
        drive(1'b0, 2);
        arm();
        drive(1'b1, 2);
        push(2, 63, 1'b1, cyc + 64 + SYNC_LAT);
        drive(1'b0, 70);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL sat_low_busy: got %0b, required 0", busy); end
    endtask

    task automatic test_ena_while_busy();
        int at;
        drive(1'b0, 2);
        arm();
        drive(1'b0, 1);
        drive(1'b1, 1);
        ena = 1'b1;
        drive(1'b1, 2);
        ena = 1'b0;
        drive(1'b0, 3);
        at = cyc + 1 + SYNC_LAT;
        push(3, 3, 1'b0, at);
        din = 1'b1;
        wait_until(at + 1);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL ena_not_queued: got busy=%0b, required 0", busy); end
        drive(1'b1, 2);
        drive(1'b0, 3);
        drive(1'b1, 3);
        drive(1'b0, 3);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL ena_idle_after: got busy=%0b, required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int at;
        drive(1'b0, 2);
        arm();
        drive(1'b0, 1);
        drive(1'b1, 4);
        drive(1'b0, 2);
        at = cyc + 1 + SYNC_LAT;
        push(4, 2, 1'b0, at);
        din = 1'b1;
        wait_until(at);
        vectors++;
        if (valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid_at: got %0b, required 1", valid); end
        arm();
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_rearm: got busy=%0b, required 1", busy); end
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b1, 3);
        drive(1'b0, 2);
        at = cyc + 1 + SYNC_LAT;
        push(3, 2, 1'b0, at);
        din = 1'b1;
        wait_until(at + 1);
    endtask

    task automatic test_reset_mid();
        int at;
        drive(1'b0, 2);
        arm();
        drive(1'b1, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors += 5;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %0b, required 0", busy); end
        if (hi_cnt !== '0) begin miscompares++; $display("FAIL mid_rst_hi_cnt: got %0d, required 0", hi_cnt); end
        if (lo_cnt !== '0) begin miscompares++; $display("FAIL mid_rst_lo_cnt: got %0d, required 0", lo_cnt); end
        if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %0b, required 0", valid); end
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ovf: got %0b, required 0", ovf); end
        drive(1'b1, 2);
        drive(1'b0, 3);
        arm();
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 2);
        at = cyc + 1 + SYNC_LAT;
        push(2, 2, 1'b0, at);
        din = 1'b1;
        wait_until(at + 1);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        din   = 1'b0;
        test_reset();
        test_basic();
        test_already_high();
        test_sat_high();
        test_sat_low();
        test_ena_while_busy();
        test_back_to_back();
        test_reset_mid();
        for (int i = 0; i < 200 && sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d reports outstanding, required 0", sb.size());
        end
        drive(din, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
